// File: rtl/clock_digits_pkg.sv
// Shared types and constants for the clock_digits time-of-day display:
// segment codes, field-select encodings and BCD pair increment helper.
package clock_digits_pkg;

   // Active-low segment codes, bit7 = dp (off), bits6:0 = g..a
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic [1:0] {
      FIELD_SEC  = 2'd0,
      FIELD_MIN  = 2'd1,
      FIELD_HOUR = 2'd2,
      FIELD_NONE = 2'd3
   } field_e;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] units;
   } bcd_pair_t;

   typedef struct packed {
      bcd_pair_t hour;
      bcd_pair_t min;
      bcd_pair_t sec;
   } clock_time_t;

   // A packed BCD pair reads like its hex value, so 59 is 8'h59.
   localparam bcd_pair_t LAST_MIN_SEC = 8'h59;
   localparam bcd_pair_t LAST_HOUR    = 8'h23;

   function automatic bcd_pair_t bcd_pair_inc(input bcd_pair_t p, input bcd_pair_t last);
      bcd_pair_t r;
      if (p == last) begin
         r = '0;
      end else if (p.units == 4'd9) begin
         r.tens  = p.tens + 4'd1;
         r.units = 4'd0;
      end else begin
         r.tens  = p.tens;
         r.units = p.units + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment code; dp is left off
// here and driven by the top level. Non-BCD input blanks the digit.
module bcd_to_seg
   import clock_digits_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [7:0] seg
);

   always_comb begin
      // NOTE: the default arm assigns seg on every path, so no latch is inferred.
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/clock_digits.sv
// HH:MM:SS clock with one-second prescaler, field-set mode with blinking,
// and six registered active-low 7-segment outputs.
module clock_digits
   import clock_digits_pkg::*;
#(
   parameter int CLK_FREQ = 100000000,
   parameter int HALF_CNT = CLK_FREQ / 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_en,
   input  logic [1:0] set_field,
   input  logic       inc_pulse,
   input  logic       clear,
   output logic       sec_tick,
   output logic [7:0] seg_data_0,
   output logic [7:0] seg_data_1,
   output logic [7:0] seg_data_2,
   output logic [7:0] seg_data_3,
   output logic [7:0] seg_data_4,
   output logic [7:0] seg_data_5
);

   localparam int              CNT_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_FREQ - 1);

   clock_time_t      time_q;
   logic [CNT_W-1:0] presc_cnt;
   logic [CNT_W-1:0] blink_cnt;

   // Time and prescaler; priority is clear, then set-mode increment, then tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         time_q    <= '0;
         presc_cnt <= '0;
         sec_tick  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every register sample the old state of its peers.
         sec_tick <= 1'b0;
         if (clear) begin
            time_q    <= '0;
            presc_cnt <= '0;
         end else if (set_en) begin
            presc_cnt <= '0;
            if (inc_pulse) begin
               case (field_e'(set_field))
                  FIELD_SEC:  time_q.sec  <= bcd_pair_inc(time_q.sec,  LAST_MIN_SEC);
                  FIELD_MIN:  time_q.min  <= bcd_pair_inc(time_q.min,  LAST_MIN_SEC);
                  FIELD_HOUR: time_q.hour <= bcd_pair_inc(time_q.hour, LAST_HOUR);
                  FIELD_NONE: ;
               endcase
            end
         end else if (presc_cnt == LAST_CNT) begin
            presc_cnt  <= '0;
            sec_tick   <= 1'b1;
            time_q.sec <= bcd_pair_inc(time_q.sec, LAST_MIN_SEC);
            if (time_q.sec == LAST_MIN_SEC) begin
               time_q.min <= bcd_pair_inc(time_q.min, LAST_MIN_SEC);
               if (time_q.min == LAST_MIN_SEC)
                  time_q.hour <= bcd_pair_inc(time_q.hour, LAST_HOUR);
            end
         end else begin
            presc_cnt <= presc_cnt + 1'b1;
         end
      end
   end

   // Blink phase only advances in set mode so the selected field starts visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         blink_cnt <= '0;
      else if (!set_en || blink_cnt == LAST_CNT)
         blink_cnt <= '0;
      else
         blink_cnt <= blink_cnt + 1'b1;
   end

   logic [3:0] digit    [6];
   logic [7:0] code     [6];
   logic [7:0] seg_next [6];
   logic [7:0] seg_q    [6];
   logic       blink_hi;
   logic       dp_lit;

   assign digit[0] = time_q.sec.units;
   assign digit[1] = time_q.sec.tens;
   assign digit[2] = time_q.min.units;
   assign digit[3] = time_q.min.tens;
   assign digit[4] = time_q.hour.units;
   assign digit[5] = time_q.hour.tens;

   assign blink_hi = set_en && (int'(blink_cnt) >= HALF_CNT);
   assign dp_lit   = time_q.sec.units[0];

   for (genvar i = 0; i < 6; i++) begin : g_digit
      localparam logic [1:0] FIELD_OF = 2'(i / 2);
      localparam logic       HAS_DP   = (i == 2) || (i == 4);

      bcd_to_seg u_dec (
         .bcd (digit[i]),
         .seg (code[i])
      );

      assign seg_next[i] = (blink_hi && set_field == FIELD_OF) ? SEG_BLANK
                         : {code[i][7] & ~(HAS_DP & dp_lit), code[i][6:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: this small output register array is reset (unlike a RAM) so the display shows 00:00:00.
         for (int i = 0; i < 6; i++) seg_q[i] <= SEG_0;
      end else begin
         seg_q <= seg_next;
      end
   end

   assign seg_data_0 = seg_q[0];
   assign seg_data_1 = seg_q[1];
   assign seg_data_2 = seg_q[2];
   assign seg_data_3 = seg_q[3];
   assign seg_data_4 = seg_q[4];
   assign seg_data_5 = seg_q[5];

endmodule

// File: tb/tb_clock_digits.sv
// Self-checking bench for clock_digits: directed scenarios plus random
// stimulus, compared every cycle against a seconds-of-day reference model.
module tb_clock_digits;

   localparam int F = 10;
   localparam int H = 5;
   localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       set_en = 1'b0;
   logic [1:0] set_field = 2'd3;
   logic       inc_pulse = 1'b0;
   logic       clear = 1'b0;
   logic       sec_tick;
   logic [7:0] seg_data_0, seg_data_1, seg_data_2, seg_data_3, seg_data_4, seg_data_5;
   logic [7:0] dut_seg [6];

   always #5 clk = ~clk;

   clock_digits #(.CLK_FREQ(F), .HALF_CNT(H)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_en     (set_en),
      .set_field  (set_field),
      .inc_pulse  (inc_pulse),
      .clear      (clear),
      .sec_tick   (sec_tick),
      .seg_data_0 (seg_data_0),
      .seg_data_1 (seg_data_1),
      .seg_data_2 (seg_data_2),
      .seg_data_3 (seg_data_3),
      .seg_data_4 (seg_data_4),
      .seg_data_5 (seg_data_5)
   );

   assign dut_seg[0] = seg_data_0;
   assign dut_seg[1] = seg_data_1;
   assign dut_seg[2] = seg_data_2;
   assign dut_seg[3] = seg_data_3;
   assign dut_seg[4] = seg_data_4;
   assign dut_seg[5] = seg_data_5;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: time as seconds of the day, counters as plain integers.
   int         m_secs, m_presc, m_blink;
   bit         m_tick;
   logic [7:0] m_seg [6];

   task automatic model_reset();
      m_secs = 0; m_presc = 0; m_blink = 0; m_tick = 0;
      for (int d = 0; d < 6; d++) m_seg[d] = 8'hC0;
   endtask

   function automatic logic [7:0] exp_digit(input int d);
      int h, mi, s;
      int val [6];
      logic [7:0] code;
      h  = m_secs / 3600;
      mi = (m_secs / 60) % 60;
      s  = m_secs % 60;
      val = '{s % 10, s / 10, mi % 10, mi / 10, h % 10, h / 10};
      if (set_en && int'(set_field) == d / 2 && m_blink >= H) return 8'hFF;
      code = SEG_TAB[val[d]];
      if ((d == 2 || d == 4) && (s % 2 == 1)) code[7] = 1'b0;
      return code;
   endfunction

   task automatic model_edge();
      logic [7:0] nxt [6];
      int h, mi, s;
      for (int d = 0; d < 6; d++) nxt[d] = exp_digit(d);
      m_seg   = nxt;
      m_blink = set_en ? (m_blink + 1) % F : 0;
      m_tick  = 0;
      h  = m_secs / 3600;
      mi = (m_secs / 60) % 60;
      s  = m_secs % 60;
      if (clear) begin
         m_secs = 0; m_presc = 0;
      end else if (set_en) begin
         m_presc = 0;
         if (inc_pulse) begin
            case (set_field)
               2'd0: s  = (s + 1) % 60;
               2'd1: mi = (mi + 1) % 60;
               2'd2: h  = (h + 1) % 24;
               default: ;
            endcase
         end
         m_secs = h * 3600 + mi * 60 + s;
      end else if (m_presc == F - 1) begin
         m_presc = 0; m_tick = 1; m_secs = (m_secs + 1) % 86400;
      end else begin
         m_presc++;
      end
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("sec_tick", sec_tick, m_tick);
      for (int d = 0; d < 6; d++) check($sformatf("seg%0d", d), dut_seg[d], m_seg[d]);
   endtask

   task automatic bump(input int field, input int n);
      set_en = 1'b1;
      set_field = 2'(field);
      for (int k = 0; k < n; k++) begin
         inc_pulse = 1'b1; cycle();
         inc_pulse = 1'b0; cycle();
      end
   endtask

   task automatic do_clear();
      clear = 1'b1; cycle(); clear = 1'b0;
   endtask

   initial begin
      model_reset();
      @(negedge clk); @(negedge clk);
      check("rst_tick", sec_tick, 1'b0);
      for (int d = 0; d < 6; d++) check($sformatf("rst_seg%0d", d), dut_seg[d], 8'hC0);
      rst_n = 1'b1;

      // First second after reset release
      for (int k = 0; k < 9; k++) begin
         cycle();
         check("idle_tick", sec_tick, 1'b0);
      end
      for (int d = 0; d < 6; d++) check($sformatf("idle_seg%0d", d), dut_seg[d], 8'hC0);
      cycle();
      check("first_tick", sec_tick, 1'b1);
      cycle();
      check("first_sec_seg0", seg_data_0, 8'hF9);
      check("first_sec_dp", seg_data_2[7], 1'b0);

      // 23:59:59 rolls over to 00:00:00
      set_en = 1'b1;
      do_clear();
      bump(0, 59); bump(1, 59); bump(2, 23);
      set_field = 2'd3;
      set_en = 1'b0;
      for (int k = 0; k < 9; k++) begin
         cycle();
         check("roll_notick", sec_tick, 1'b0);
      end
      cycle();
      check("roll_tick", sec_tick, 1'b1);
      cycle();
      for (int d = 0; d < 6; d++) check($sformatf("roll_seg%0d", d), dut_seg[d], 8'hC0);

      // Minute field wraps with no carry into hours
      set_en = 1'b1;
      do_clear();
      bump(0, 5); bump(2, 3); bump(1, 59); bump(1, 1);
      set_field = 2'd3;
      cycle(); cycle();
      check("minwrap_seg0", seg_data_0, 8'h92);
      check("minwrap_seg1", seg_data_1, 8'hC0);
      check("minwrap_seg2", seg_data_2, 8'h40);
      check("minwrap_seg3", seg_data_3, 8'hC0);
      check("minwrap_seg4", seg_data_4, 8'h30);
      check("minwrap_seg5", seg_data_5, 8'hC0);

      // clear wins over inc_pulse at 12:34:56
      do_clear();
      bump(2, 12); bump(1, 34); bump(0, 56);
      set_field = 2'd0;
      clear = 1'b1; inc_pulse = 1'b1;
      cycle();
      clear = 1'b0; inc_pulse = 1'b0; set_field = 2'd3;
      cycle();
      for (int d = 0; d < 6; d++) check($sformatf("clrinc_seg%0d", d), dut_seg[d], 8'hC0);

      // Hour field blinks in the upper half of the blink period
      set_en = 1'b0;
      cycle();
      set_en = 1'b1; set_field = 2'd2;
      for (int k = 1; k <= 12; k++) begin
         cycle();
         check($sformatf("blink_hr4_%0d", k), seg_data_4 == 8'hFF, (k >= 6 && k <= 10));
         check($sformatf("blink_hr5_%0d", k), seg_data_5 == 8'hFF, (k >= 6 && k <= 10));
         check($sformatf("blink_sec_%0d", k), seg_data_0 == 8'hFF, 1'b0);
      end

      // Async reset mid-second at 00:00:07
      set_en = 1'b0; set_field = 2'd3;
      do_clear();
      for (int k = 0; k < 73; k++) cycle();
      check("pre_rst_seg0", seg_data_0, 8'hF8);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_tick", sec_tick, 1'b0);
      for (int d = 0; d < 6; d++) check($sformatf("arst_seg%0d", d), dut_seg[d], 8'hC0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 9; k++) begin
         cycle();
         check("arst_notick", sec_tick, 1'b0);
      end
      cycle();
      check("arst_tick10", sec_tick, 1'b1);

      // Random stimulus against the model
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 39) == 0) set_en = ~set_en;
         if ($urandom_range(0, 7) == 0) set_field = 2'($urandom_range(0, 3));
         inc_pulse = ($urandom_range(0, 2) == 0);
         clear     = ($urandom_range(0, 199) == 0);
         cycle();
      end
      inc_pulse = 1'b0; clear = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
